// File: rtl/fx2fp16_vec_seq_pkg.sv
// Shared definitions for the fixed-point to fp16 vector sequencer:
// FSM encoding, timeout result value and default geometry.
package fx2fp16_vec_seq_pkg;

  localparam int DEF_N       = 32;
  localparam int DEF_LANES   = 8;
  localparam int DEF_TIMEOUT = 48;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/fx2fp16_vec_seq_if.sv
// Bundle of the input vector, converter and output vector handshakes.
// slave = sequencer side, master = environment (source, converter, sink).
interface fx2fp16_vec_seq_if
  import fx2fp16_vec_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int LANES = DEF_LANES
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*N-1:0]    in_data;
  logic [5:0]            in_scale;
  logic [N-1:0]          cv_fixed;
  logic [5:0]            cv_scale;
  logic                  cv_start;
  logic [15:0]           cv_float;
  logic                  cv_done;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*16-1:0]   out_data;
  logic [LANES-1:0]      out_err;

  modport slave (
    input  in_valid, in_data, in_scale, cv_float, cv_done, out_ready,
    output in_ready, cv_fixed, cv_scale, cv_start, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_data, in_scale, cv_float, cv_done, out_ready,
    input  in_ready, cv_fixed, cv_scale, cv_start, out_valid, out_data, out_err
  );

endinterface

// File: rtl/fx2fp16_lane_timer.sv
// Per-lane saturating wait counter; expired_o flags the cycle that would be
// the TIMEOUT-th consecutive cycle without a converter completion.
module fx2fp16_lane_timer
  import fx2fp16_vec_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT       = CW'(TIMEOUT);
  localparam logic [CW-1:0]   LAST_ABSENT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts the absent cycles already elapsed in this lane's wait
  assign expired_o = en_i && (cnt_q >= LAST_ABSENT);

endmodule

// File: rtl/fx2fp16_vec_seq.sv
// Sequences a vector of fixed-point lanes through one external fp16 converter,
// one lane at a time, with a per-lane completion timeout.
module fx2fp16_vec_seq
  import fx2fp16_vec_seq_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int LANES   = DEF_LANES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  fx2fp16_vec_seq_if.slave   bus
);

  localparam int            IW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [LANES*N-1:0]   vec_q, vec_d;
  logic [5:0]           scale_q, scale_d;
  logic [LANES*16-1:0]  res_q, res_d;
  logic [LANES-1:0]     err_q, err_d;
  logic                 timer_clr, timer_en, expired;
  logic [N-1:0]         lane_w [LANES];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_w[gi] = vec_q[gi*N +: N];
    end
  endgenerate

  assign timer_clr = (state_q == ST_ISSUE);
  assign timer_en  = (state_q == ST_WAIT);

  fx2fp16_lane_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    scale_d = scale_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          vec_d   = bus.in_data;
          scale_d = bus.in_scale;
          idx_d   = '0;
          res_d   = '0;
          err_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // a real completion wins over an expiry in the same cycle
        if (bus.cv_done || expired) begin
          for (int i = 0; i < LANES; i++) begin
            if (idx_q == IW'(i)) begin
              res_d[i*16 +: 16] = bus.cv_done ? bus.cv_float : FP16_QNAN;
              err_d[i]          = ~bus.cv_done;
            end
          end
          if (idx_q == LAST) begin
            state_d = ST_OUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      scale_q <= '0;
      res_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      scale_q <= scale_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.cv_start  = (state_q == ST_ISSUE);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.cv_fixed  = lane_w[idx_q];
  assign bus.cv_scale  = scale_q;
  assign bus.out_data  = res_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_fx2fp16_vec_seq.sv
// Self-checking bench: converter stub, lane-level reference model and
// directed/randomized vector sequence.
module tb_fx2fp16_vec_seq;
  import fx2fp16_vec_seq_pkg::*;

  localparam int N       = 32;
  localparam int LANES   = 8;
  localparam int TIMEOUT = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fx2fp16_vec_seq_if #(.N(N), .LANES(LANES)) bus ();

  fx2fp16_vec_seq #(.N(N), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // stub state (written only by stub_run) and its configuration (written by main)
  int start_cnt = 0, pend = 0, pend_cnt = 0, last_done_cyc = 0, inject_ack = 0;
  int width_err = 0, scale_err = 0, fixed_err = 0, stab_err = 0;
  int start_cyc [LANES];
  logic prev_start = 1'b0;
  logic [N-1:0] cur_fixed = '0;
  logic [5:0]   cur_scale = '0;
  int stub_delay = 5, stub_dead = -1, base_cnt = 0, inject_req = 0;
  logic [LANES*N-1:0] cur_vec = '0;
  logic [5:0]         exp_scale = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // converter model: result is the inverted low half of the lane, D cycles after start
  task automatic stub_run();
    int lane;
    forever begin
      @(negedge clk);
      bus.cv_done = 1'b0;
      if (inject_req != inject_ack) begin
        bus.cv_done = 1'b1;
        inject_ack  = inject_req;
      end
      if (pend != 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend          = 0;
          bus.cv_done   = 1'b1;
          last_done_cyc = cyc;
        end
      end
      if (bus.cv_start === 1'b1) begin
        lane = start_cnt - base_cnt;
        if (prev_start === 1'b1) width_err++;
        if (bus.cv_scale !== exp_scale) scale_err++;
        if (lane >= 0 && lane < LANES) begin
          if (bus.cv_fixed !== cur_vec[lane*N +: N]) fixed_err++;
          start_cyc[lane] = cyc;
        end
        cur_fixed    = bus.cv_fixed;
        cur_scale    = bus.cv_scale;
        bus.cv_float = ~bus.cv_fixed[15:0];
        if (lane != stub_dead) begin
          pend     = 1;
          pend_cnt = stub_delay;
        end
        start_cnt++;
      end else if (bus.in_ready === 1'b0 && bus.out_valid === 1'b0) begin
        if (bus.cv_fixed !== cur_fixed || bus.cv_scale !== cur_scale) stab_err++;
      end
      prev_start = bus.cv_start;
    end
  endtask

  function automatic logic [LANES*16-1:0] ref_data(input logic [LANES*N-1:0] v, input int dead);
    logic [LANES*16-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      r[i*16 +: 16] = (i == dead) ? 16'h7E00 : ~v[i*N +: 16];
    end
    return r;
  endfunction

  function automatic logic [LANES-1:0] ref_err(input int dead);
    logic [LANES-1:0] e;
    e = '0;
    for (int i = 0; i < LANES; i++) if (i == dead) e[i] = 1'b1;
    return e;
  endfunction

  // call at a falling edge; leaves the bench at a falling edge
  task automatic send_vec(input logic [LANES*N-1:0] v, input logic [5:0] s,
                          input int dead, input int d);
    int k;
    stub_dead = dead;
    stub_delay = d;
    cur_vec = v;
    exp_scale = s;
    base_cnt = start_cnt;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chki("in_ready_wait", int'(k < 500), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_scale = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("accepted", 128'(bus.in_ready), 128'(1'b0));
  endtask

  task automatic recv_vec(input int hold, input logic [LANES*16-1:0] ed,
                          input logic [LANES-1:0] ee, output int vcyc);
    int k;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chki("out_valid_wait", int'(k < 3000), 1);
    vcyc = cyc;
    $display("vector: out_data=%h out_err=%h at cycle %0d", bus.out_data, bus.out_err, cyc);
    chk("out_data", 128'(bus.out_data), 128'(ed));
    chk("out_err", 128'(bus.out_err), 128'(ee));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 128'(bus.out_valid), 128'(1'b1));
      chk("hold_data", 128'(bus.out_data), 128'(ed));
      chk("hold_in_ready", 128'(bus.in_ready), 128'(1'b0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_hs_in_ready", 128'(bus.in_ready), 128'(1'b1));
    chk("post_hs_out_valid", 128'(bus.out_valid), 128'(1'b0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1'b1));
    chk({tag, "_cv_start"}, 128'(bus.cv_start), 128'(1'b0));
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(1'b0));
    chk({tag, "_cv_fixed"}, 128'(bus.cv_fixed), 128'(0));
    chk({tag, "_cv_scale"}, 128'(bus.cv_scale), 128'(0));
    chk({tag, "_out_data"}, 128'(bus.out_data), 128'(0));
    chk({tag, "_out_err"}, 128'(bus.out_err), 128'(0));
  endtask

  function automatic logic [LANES*N-1:0] rand_vec();
    logic [LANES*N-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*N +: N] = $urandom;
    return v;
  endfunction

  initial begin
    logic [LANES*N-1:0] v;
    logic [5:0] s;
    int vcyc, dead, d, e0, e1, e2, e3, k;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_scale = '0;
    bus.cv_float = '0;   bus.cv_done = 1'b0; bus.out_ready = 1'b0;
    fork
      stub_run();
    join_none

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // lanes 1..8, scale 3, 5-cycle converter
    for (int i = 0; i < LANES; i++) v[i*N +: N] = N'(i + 1);
    e0 = scale_err; e1 = fixed_err; e2 = stab_err;
    send_vec(v, 6'd3, -1, 5);
    recv_vec(0, ref_data(v, -1), '0, vcyc);
    chki("basic_starts", start_cnt - base_cnt, LANES);
    chki("basic_scale_err", scale_err - e0, 0);
    chki("basic_fixed_err", fixed_err - e1, 0);
    chki("basic_stab_err", stab_err - e2, 0);

    // lane 2 never completes
    v = rand_vec(); s = 6'($urandom);
    send_vec(v, s, 2, 5);
    recv_vec(0, ref_data(v, 2), ref_err(2), vcyc);
    chki("timeout_gap", start_cyc[3] - start_cyc[2], TIMEOUT + 1);
    chki("timeout_starts", start_cnt - base_cnt, LANES);

    // fast converter: start spacing and output latency
    v = rand_vec(); s = 6'($urandom);
    e0 = width_err;
    send_vec(v, s, -1, 2);
    recv_vec(0, ref_data(v, -1), '0, vcyc);
    chki("fast_starts", start_cnt - base_cnt, LANES);
    chki("fast_width_err", width_err - e0, 0);
    chki("fast_gap", start_cyc[1] - start_cyc[0], 3);
    chki("fast_out_latency", vcyc, last_done_cyc + 1);

    // long backpressure, then an immediate next vector
    v = rand_vec(); s = 6'($urandom);
    send_vec(v, s, -1, 3);
    recv_vec(20, ref_data(v, -1), '0, vcyc);
    v = rand_vec(); s = 6'($urandom);
    send_vec(v, s, 5, 4);
    recv_vec(1, ref_data(v, 5), ref_err(5), vcyc);

    // reset while waiting on lane 4, stray done afterwards
    v = rand_vec(); s = 6'($urandom);
    send_vec(v, s, -1, 5);
    k = 0;
    while ((start_cnt - base_cnt) < 5 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chki("lane4_wait", int'(k < 500), 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    inject_req++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stray_in_ready", 128'(bus.in_ready), 128'(1'b1));
      chk("stray_cv_start", 128'(bus.cv_start), 128'(1'b0));
      chk("stray_out_valid", 128'(bus.out_valid), 128'(1'b0));
    end
    chk("stray_out_data", 128'(bus.out_data), 128'(0));
    chk("stray_out_err", 128'(bus.out_err), 128'(0));
    v = rand_vec(); s = 6'($urandom);
    send_vec(v, s, -1, 5);
    recv_vec(0, ref_data(v, -1), '0, vcyc);
    chki("after_rst_starts", start_cnt - base_cnt, LANES);

    // randomized vectors
    e0 = scale_err; e1 = fixed_err; e2 = stab_err; e3 = width_err;
    for (int t = 0; t < 5; t++) begin
      v = rand_vec(); s = 6'($urandom);
      d = int'($urandom_range(1, 8));
      dead = int'($urandom_range(0, LANES)) - 1;
      send_vec(v, s, dead, d);
      recv_vec(int'($urandom_range(0, 3)), ref_data(v, dead), ref_err(dead), vcyc);
    end
    chki("rand_scale_err", scale_err - e0, 0);
    chki("rand_fixed_err", fixed_err - e1, 0);
    chki("rand_stab_err", stab_err - e2, 0);
    chki("rand_width_err", width_err - e3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fx2fp16_vec_seq.md
FX2FP16_VEC_SEQ -- requirements
Module: fx2fp16_vec_seq

Interface
REQ-001 SHALL have parameter N, default 32, fixed-point lane width.
REQ-002 SHALL have parameter LANES, default 8, lanes per vector.
REQ-003 SHALL have parameter TIMEOUT, default 48, maximum cycles to wait for cv_done per lane.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  input vector valid.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts a vector.
REQ-008 SHALL have port in_data  input  LANES*N  fixed-point lanes; lane i at [i*N +: N].
REQ-009 SHALL have port in_scale  input  6  scaling factor for the whole vector.
REQ-010 SHALL have port cv_fixed  output  N  lane value to the converter.
REQ-011 SHALL have port cv_scale  output  6  scaling factor to the converter.
REQ-012 SHALL have port cv_start  output  1  one-cycle converter start pulse.
REQ-013 SHALL have port cv_float  input  16  converter fp16 result.
REQ-014 SHALL have port cv_done  input  1  converter one-cycle completion pulse.
REQ-015 SHALL have port out_valid  output  1  result vector valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts result.
REQ-017 SHALL have port out_data  output  LANES*16  fp16 lanes; lane i at [i*16 +: 16].
REQ-018 SHALL have port out_err  output  LANES  per-lane timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT.
REQ-020 IDLE: in_ready=1; on in_valid&in_ready, SHALL register in_data and in_scale, clear lane index, out_err and out_data, then go to ISSUE.
REQ-021 ISSUE: SHALL drive cv_start=1 for exactly one cycle, with cv_fixed=registered lane[idx] and cv_scale=registered scale; next state WAIT; clear timeout counter.
REQ-022 cv_fixed and cv_scale SHALL stay stable from ISSUE until the lane leaves WAIT.
REQ-023 WAIT: on cv_done, SHALL store cv_float into out_data lane idx.
REQ-024 WAIT: if cv_done is absent for TIMEOUT consecutive cycles, SHALL store 16'h7E00 into lane idx and set out_err[idx].
REQ-025 On lane completion (done or timeout), SHALL go to ISSUE with idx+1 if idx<LANES-1, else to OUT.
REQ-026 cv_done outside WAIT, including the cycle of ISSUE, SHALL be ignored.
REQ-027 OUT: out_valid=1, out_data/out_err held stable; on out_ready SHALL go to IDLE.
REQ-028 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in OUT; there is no overlap of input and output vectors.
REQ-029 Per-lane latency SHALL be 1 (ISSUE) + cycles until cv_done; the vector's first out_valid cycle SHALL follow the last lane completion by exactly one cycle.
REQ-030 Timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, saturating, and SHALL not wrap.
REQ-031 out_ready held high in OUT SHALL release after one cycle; IDLE SHALL accept a new vector on the following cycle.

Reset
REQ-032 rst SHALL asynchronously force IDLE: in_ready=1, cv_start=0, out_valid=0, cv_fixed=0, cv_scale=0, out_data=0, out_err=0, idx=0, and timeout counter=0.
REQ-033 rst mid-vector SHALL discard all partial results; a cv_done arriving after reset release SHALL be ignored per REQ-026.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the timeout NaN constant 16'h7E00, and the default N/LANES/TIMEOUT values.
REQ-035 The converter SHALL stay external; one natural sub-module is fx2fp16_lane_timer (loadable saturating counter with expiry flag).

Verification
REQ-036 Converter stub returns ~fixed[15:0] after 5 cycles; scale=3, lanes 0..7 = 32'h00000001..8 -> out_data lanes FFFE..FFF7, out_err=0, scale 3 on every cv_start.
REQ-037 Stub never asserts done on lane 2 -> lane 2 = 16'h7E00 at TIMEOUT=48 cycles after ISSUE; out_err=8'h04; other lanes correct.
REQ-038 Stub asserts done 2 cycles after start -> exactly 8 cv_start pulses, each one cycle wide; out_valid 1 cycle after last done.
REQ-039 out_ready low for 20 cycles in OUT -> out_data/out_valid held; in_ready=0 throughout; new vector accepted the cycle after the out handshake.
REQ-040 rst asserted during WAIT on lane 4, late cv_done injected after release -> IDLE, all outputs at reset values, stray done ignored, next vector correct.
